// File: rtl/shared_toggle_arb_pkg.sv
// Shared types and constants for the shared toggle-register arbiter and
// the round-robin pickers that reuse its encoding.
package shared_toggle_arb_pkg;

   localparam int N_REQ_DEF = 4;
   localparam int W_DEF     = 8;
   localparam int CNT_W     = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARB   = 2'd1,
      ST_APPLY = 2'd2
   } state_t;

endpackage

// File: rtl/shared_toggle_arb_if.sv
// Requester-side bus of the shared toggle arbiter.
// SHARED_TOG_CNT_EN adds the apply_cnt observation signal.
interface shared_toggle_arb_if
   import shared_toggle_arb_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int W     = W_DEF
);

   logic [N_REQ-1:0]   req;
   logic [N_REQ*W-1:0] mask;
   logic [N_REQ-1:0]   gnt;
   logic [N_REQ-1:0]   ack;
   logic [W-1:0]       tog_q;
   logic               busy;
`ifdef SHARED_TOG_CNT_EN
   logic [CNT_W-1:0]   apply_cnt;

   modport master (output req, mask, input gnt, ack, tog_q, busy, apply_cnt);
   modport slave  (input req, mask, output gnt, ack, tog_q, busy, apply_cnt);
`else
   modport master (output req, mask, input gnt, ack, tog_q, busy);
   modport slave  (input req, mask, output gnt, ack, tog_q, busy);
`endif

endinterface

// File: rtl/shared_toggle_arb_rr_pick.sv
// Combinational round-robin select: first set req bit scanning upward from
// rr_ptr with wrap. rr_ptr must be below N_REQ.
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int PW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PW-1:0]    rr_ptr,
   output logic [PW-1:0]    idx,
   output logic             vld
);

   logic [PW-1:0] j;

   // Walk offsets from farthest to nearest so the nearest hit wins.
   always_comb begin
      idx = '0;
      vld = 1'b0;
      j   = '0;
      for (int k = N_REQ-1; k >= 0; k--) begin
         j = PW'((int'(rr_ptr) + k) % N_REQ);
         if (req[j]) begin
            idx = j;
            vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/shared_toggle_arb.sv
// Round-robin shared T-flip-flop bank: one requester mask XORed in per grant.
// Define SHARED_TOG_CNT_EN for the saturating nonzero-apply counter.
module shared_toggle_arb
   import shared_toggle_arb_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int W     = W_DEF
) (
   input logic               clk,
   input logic               rst_n,
   shared_toggle_arb_if.slave bus
);

   localparam int PW = $clog2(N_REQ);

   state_t                  state;
   logic [PW-1:0]           winner, rr_ptr, nxt_ptr, pick_idx;
   logic                    pick_vld;
   logic [N_REQ-1:0][W-1:0] mask_a;
   logic [W-1:0]            win_mask;
   logic [N_REQ-1:0]        gnt, ack;
   logic [W-1:0]            tog_q;
   logic                    busy;

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req    (bus.req),
      .rr_ptr (rr_ptr),
      .idx    (pick_idx),
      .vld    (pick_vld)
   );

   assign mask_a   = bus.mask;
   assign win_mask = mask_a[winner];
   assign nxt_ptr  = (int'(winner) == N_REQ-1) ? '0 : winner + 1'b1;

`ifdef SHARED_TOG_CNT_EN
   logic [CNT_W-1:0] apply_cnt;
   assign bus.apply_cnt = apply_cnt;
`endif

   // Outputs are registered, so the toggle/ack/pointer work is done on the
   // edge entering APPLY; it is then visible for the whole APPLY cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         winner <= '0;
         rr_ptr <= '0;
         gnt    <= '0;
         ack    <= '0;
         tog_q  <= '0;
         busy   <= 1'b0;
`ifdef SHARED_TOG_CNT_EN
         apply_cnt <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               ack <= '0;
               if (pick_vld) begin
                  winner <= pick_idx;
                  gnt    <= N_REQ'(1) << pick_idx;
                  busy   <= 1'b1;
                  state  <= ST_ARB;
               end
            end
            ST_ARB: begin
               ack    <= N_REQ'(1) << winner;
               tog_q  <= tog_q ^ win_mask;
               rr_ptr <= nxt_ptr;
`ifdef SHARED_TOG_CNT_EN
               if (|win_mask && apply_cnt != '1)
                  apply_cnt <= apply_cnt + 1'b1;
`endif
               state  <= ST_APPLY;
            end
            ST_APPLY: begin
               gnt   <= '0;
               ack   <= '0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.gnt   = gnt;
   assign bus.ack   = ack;
   assign bus.tog_q = tog_q;
   assign bus.busy  = busy;

endmodule

// File: tb/tb_shared_toggle_arb.sv
// Directed bench for shared_toggle_arb (N_REQ=4, W=8); apply_cnt checks
// are compiled in with SHARED_TOG_CNT_EN.
module tb_shared_toggle_arb;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
`ifdef SHARED_TOG_CNT_EN
   int   exp_cnt = 0;
`endif

   shared_toggle_arb_if #(.N_REQ(4), .W(8)) bus ();

   shared_toggle_arb #(.N_REQ(4), .W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One full grant: ARB, APPLY, back to IDLE. next_req is driven once ack is seen.
   task automatic serve(input int idx, input logic [7:0] exp_tog, input logic [3:0] next_req);
      logic [3:0] oh;
      oh = 4'(1 << idx);
      tick();
      chk("gnt_arb", 32'(bus.gnt), 32'(oh));
      chk("ack_arb", 32'(bus.ack), 32'h0);
      chk("busy_arb", 32'(bus.busy), 32'h1);
`ifdef SHARED_TOG_CNT_EN
      if (bus.mask[idx*8 +: 8] != 8'h00) exp_cnt++;
`endif
      tick();
      chk("ack_apply", 32'(bus.ack), 32'(oh));
      chk("gnt_apply", 32'(bus.gnt), 32'(oh));
      chk("tog_apply", 32'(bus.tog_q), 32'(exp_tog));
`ifdef SHARED_TOG_CNT_EN
      chk("apply_cnt", 32'(bus.apply_cnt), 32'(exp_cnt));
`endif
      bus.req = next_req;
      tick();
      chk("gnt_idle", 32'(bus.gnt), 32'h0);
      chk("ack_idle", 32'(bus.ack), 32'h0);
      chk("busy_idle", 32'(bus.busy), 32'h0);
   endtask

   initial begin
      rst_n    = 1'b1;
      bus.req  = '0;
      bus.mask = '0;
      #1 rst_n = 1'b0;
      tick();
      tick();
      chk("rst_tog", 32'(bus.tog_q), 32'h0);
      chk("rst_gnt", 32'(bus.gnt), 32'h0);
      chk("rst_ack", 32'(bus.ack), 32'h0);
      chk("rst_busy", 32'(bus.busy), 32'h0);
      rst_n = 1'b1;
      tick();

      // Single requester, toggle property on repeated masks
      bus.mask = {8'h00, 8'h00, 8'h00, 8'h0F};
      bus.req  = 4'b0001;
      serve(0, 8'h0F, 4'b0000);
      bus.mask = {8'h00, 8'h00, 8'h00, 8'hFF};
      bus.req  = 4'b0001;
      serve(0, 8'hF0, 4'b0000);
      bus.req  = 4'b0001;
      serve(0, 8'h0F, 4'b0000);

      // Reset back to rr_ptr=0, then all four held
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
`ifdef SHARED_TOG_CNT_EN
      exp_cnt = 0;
`endif
      chk("rst2_tog", 32'(bus.tog_q), 32'h0);
      bus.mask = {8'h08, 8'h04, 8'h02, 8'h01};
      bus.req  = 4'b1111;
      serve(0, 8'h01, 4'b1111);
      serve(1, 8'h03, 4'b1111);
      serve(2, 8'h07, 4'b1111);
      serve(3, 8'h0F, 4'b1111);
      serve(0, 8'h0E, 4'b0000);

      // Move rr_ptr to 2, then 0 must beat 1 after wrap
      bus.req = 4'b0010;
      serve(1, 8'h0C, 4'b0000);
      bus.req = 4'b0011;
      serve(0, 8'h0D, 4'b0010);
      serve(1, 8'h0F, 4'b0000);

      // Zero mask from requester 3
      bus.mask = {8'h00, 8'h04, 8'h02, 8'h01};
      bus.req  = 4'b1000;
      serve(3, 8'h0F, 4'b0000);

      // Asynchronous reset while in APPLY with tog_q=AA
      bus.mask = {8'h00, 8'hA5, 8'h02, 8'h01};
      bus.req  = 4'b0100;
      tick();
      chk("pre_gnt", 32'(bus.gnt), 32'h4);
      tick();
      chk("pre_tog", 32'(bus.tog_q), 32'hAA);
      chk("pre_ack", 32'(bus.ack), 32'h4);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_tog", 32'(bus.tog_q), 32'h0);
      chk("arst_gnt", 32'(bus.gnt), 32'h0);
      chk("arst_ack", 32'(bus.ack), 32'h0);
      chk("arst_busy", 32'(bus.busy), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
`ifdef SHARED_TOG_CNT_EN
      exp_cnt = 0;
`endif
      serve(2, 8'hA5, 4'b0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
